// File: rtl/cva6_l2_tlb_pkg.sv
// Shared types and geometry for the 4 KiB-page L2 TLB.
package cva6_l2_tlb_pkg;

    localparam int unsigned L2TLB_ENTRIES = 128;
    localparam int unsigned L2TLB_ASSOC   = 4;
    localparam int unsigned L2TLB_SETS    = L2TLB_ENTRIES / L2TLB_ASSOC;
    localparam int unsigned L2TLB_IDX_W   = $clog2(L2TLB_SETS);
    localparam int unsigned L2TLB_WAY_W   = $clog2(L2TLB_ASSOC);
    localparam int unsigned L2TLB_VPN_W   = 27;
    localparam int unsigned L2TLB_TAG_W   = L2TLB_VPN_W - L2TLB_IDX_W;
    localparam int unsigned L2TLB_PPN_W   = 44;
    localparam int unsigned L2TLB_ASID_W  = 16;
    localparam int unsigned L2TLB_PERM_W  = 8;

    // PTE permission byte layout: D,A,G,U,X,W,R,V (bit 7 .. bit 0)
    localparam int unsigned PERM_G_BIT    = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2,
        ST_REFILL = 2'd3
    } l2tlb_state_e;

    typedef struct packed {
        logic                      valid;
        logic [L2TLB_TAG_W-1:0]    tag;
        logic [L2TLB_ASID_W-1:0]   asid;
        logic [L2TLB_PPN_W-1:0]    ppn;
        logic [L2TLB_PERM_W-1:0]   perm;
    } tlb_entry_t;

endpackage

// File: rtl/cva6_l2_tlb_plru.sv
// Per-set tree pseudo-LRU state. A tree bit points toward the victim side:
// 0 = lower half, 1 = upper half. Touching a way flips its path away from it.
module cva6_l2_tlb_plru #(
    parameter int unsigned Sets  = 32,
    parameter int unsigned Assoc = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      upd_en_i,
    input  logic [$clog2(Sets)-1:0]   upd_set_i,
    input  logic [$clog2(Assoc)-1:0]  upd_way_i,
    input  logic [$clog2(Sets)-1:0]   victim_set_i,
    output logic [$clog2(Assoc)-1:0]  victim_way_c_o
);

    localparam int unsigned WayW = $clog2(Assoc);

    // Heap-ordered tree nodes 1..Assoc-1; node n has children 2n and 2n+1
    logic [Assoc-1:1] tree_q [Sets];
    logic [Assoc-1:1] tree_upd_c;
    logic [Assoc-1:1] tree_vic_c;
    logic [WayW:0]    leaf_c;
    logic [WayW:0]    node_c;

    // New tree value for the touched set: every node on the path points away
    always_comb begin
        leaf_c     = {1'b1, upd_way_i};
        tree_upd_c = tree_q[upd_set_i];
        for (int unsigned l = 0; l < WayW; l++) begin
            tree_upd_c[WayW'(leaf_c >> (WayW - l))] = ~leaf_c[WayW - 1 - l];
        end
    end

    // Victim walk from the root following the tree bits
    always_comb begin
        tree_vic_c = tree_q[victim_set_i];
        node_c     = (WayW + 1)'(1);
        for (int unsigned l = 0; l < WayW; l++) begin
            node_c = {node_c[WayW-1:0], tree_vic_c[WayW'(node_c)]};
        end
        victim_way_c_o = node_c[WayW-1:0];
    end

    // Tree state storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < Sets; s++) begin
                tree_q[s] <= '0;
            end
        end else if (upd_en_i) begin
            tree_q[upd_set_i] <= tree_upd_c;
        end
    end

endmodule

// File: rtl/cva6_l2_tlb_4k.sv
// Set-associative L2 TLB for 4 KiB Sv39 pages, fed by the L1 TLB miss path
// and refilled by the PTW. One lookup or refill in flight at a time.
// Optional hit/miss counters are compiled in with CVA6_L2TLB_PERF_CNT_EN.
module cva6_l2_tlb_4k
    import cva6_l2_tlb_pkg::*;
#(
    parameter int unsigned Entries = L2TLB_ENTRIES,
    parameter int unsigned Assoc   = L2TLB_ASSOC,
    parameter int unsigned VpnW    = L2TLB_VPN_W,
    parameter int unsigned PpnW    = L2TLB_PPN_W,
    parameter int unsigned AsidW   = L2TLB_ASID_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [VpnW-1:0]   req_vpn_i,
    input  logic [AsidW-1:0]  req_asid_i,
    output logic              rsp_valid_o,
    output logic              rsp_hit_o,
    output logic [PpnW-1:0]   rsp_ppn_o,
    output logic [7:0]        rsp_perm_o,
`ifdef CVA6_L2TLB_PERF_CNT_EN
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
`endif
    input  logic              refill_valid_i,
    output logic              refill_ready_o,
    input  logic [VpnW-1:0]   refill_vpn_i,
    input  logic [AsidW-1:0]  refill_asid_i,
    input  logic [PpnW-1:0]   refill_ppn_i,
    input  logic [7:0]        refill_perm_i
);

    localparam int unsigned Sets = Entries / Assoc;
    localparam int unsigned IdxW = $clog2(Sets);
    localparam int unsigned WayW = $clog2(Assoc);

    l2tlb_state_e      state_q, state_d;
    logic [VpnW-1:0]   vpn_q, vpn_d;
    logic [AsidW-1:0]  asid_q, asid_d;
    logic [VpnW-1:0]   ref_vpn_q, ref_vpn_d;
    logic [AsidW-1:0]  ref_asid_q, ref_asid_d;
    logic [PpnW-1:0]   ref_ppn_q, ref_ppn_d;
    logic [7:0]        ref_perm_q, ref_perm_d;
    tlb_entry_t        rd_q [Assoc];
    tlb_entry_t        rd_d [Assoc];
    tlb_entry_t        tlb_q [Sets][Assoc];

    logic [IdxW-1:0]          lk_idx_c;
    logic [L2TLB_TAG_W-1:0]   lk_tag_c;
    logic [L2TLB_ASID_W-1:0]  lk_asid_c;
    logic                     hit_any_c;
    logic                     hit_c;
    logic [WayW-1:0]          hit_way_c;
    logic [PpnW-1:0]          hit_ppn_c;
    logic [7:0]               hit_perm_c;

    logic [IdxW-1:0]          rf_idx_c;
    logic [L2TLB_TAG_W-1:0]   rf_tag_c;
    logic [L2TLB_ASID_W-1:0]  rf_asid_c;
    logic                     rf_match_c;
    logic [WayW-1:0]          rf_match_way_c;
    logic                     rf_free_c;
    logic [WayW-1:0]          rf_free_way_c;
    logic [WayW-1:0]          rf_way_c;
    logic [WayW-1:0]          victim_way_c;
    tlb_entry_t               rf_entry_c;
    logic                     wr_en_c;

    logic                     plru_upd_en_c;
    logic [IdxW-1:0]          plru_upd_set_c;
    logic [WayW-1:0]          plru_upd_way_c;

    assign lk_idx_c  = vpn_q[IdxW-1:0];
    assign lk_tag_c  = L2TLB_TAG_W'(vpn_q[VpnW-1:IdxW]);
    assign lk_asid_c = L2TLB_ASID_W'(asid_q);
    assign rf_idx_c  = ref_vpn_q[IdxW-1:0];
    assign rf_tag_c  = L2TLB_TAG_W'(ref_vpn_q[VpnW-1:IdxW]);
    assign rf_asid_c = L2TLB_ASID_W'(ref_asid_q);

    // Refill wins over a lookup; flush blocks both handshakes
    assign refill_ready_o = (state_q == ST_IDLE) && !flush_i;
    assign req_ready_o    = (state_q == ST_IDLE) && !refill_valid_i && !flush_i;

    // Tag compare on the captured set; a flush during the response kills the hit
    always_comb begin
        hit_any_c  = 1'b0;
        hit_way_c  = '0;
        hit_ppn_c  = '0;
        hit_perm_c = '0;
        for (int unsigned w = 0; w < Assoc; w++) begin
            if (!hit_any_c && rd_q[w].valid && (rd_q[w].tag == lk_tag_c) &&
                ((rd_q[w].asid == lk_asid_c) || rd_q[w].perm[PERM_G_BIT])) begin
                hit_any_c  = 1'b1;
                hit_way_c  = WayW'(w);
                hit_ppn_c  = PpnW'(rd_q[w].ppn);
                hit_perm_c = rd_q[w].perm;
            end
        end
        hit_c = hit_any_c && (state_q == ST_RESP) && !flush_i;
    end

    // Response is presented only in RESP and is zero otherwise
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_hit_o   = hit_c;
    assign rsp_ppn_o   = hit_c ? hit_ppn_c : '0;
    assign rsp_perm_o  = hit_c ? hit_perm_c : '0;

    // Refill way choice: existing tag+ASID match, else lowest invalid, else PLRU victim
    always_comb begin
        rf_match_c     = 1'b0;
        rf_match_way_c = '0;
        rf_free_c      = 1'b0;
        rf_free_way_c  = '0;
        for (int unsigned w = 0; w < Assoc; w++) begin
            if (!rf_match_c && tlb_q[rf_idx_c][w].valid &&
                (tlb_q[rf_idx_c][w].tag == rf_tag_c) &&
                (tlb_q[rf_idx_c][w].asid == rf_asid_c)) begin
                rf_match_c     = 1'b1;
                rf_match_way_c = WayW'(w);
            end
            if (!rf_free_c && !tlb_q[rf_idx_c][w].valid) begin
                rf_free_c     = 1'b1;
                rf_free_way_c = WayW'(w);
            end
        end
        if (rf_match_c) begin
            rf_way_c = rf_match_way_c;
        end else if (rf_free_c) begin
            rf_way_c = rf_free_way_c;
        end else begin
            rf_way_c = victim_way_c;
        end
        rf_entry_c.valid = 1'b1;
        rf_entry_c.tag   = rf_tag_c;
        rf_entry_c.asid  = rf_asid_c;
        rf_entry_c.ppn   = L2TLB_PPN_W'(ref_ppn_q);
        rf_entry_c.perm  = ref_perm_q;
        wr_en_c          = (state_q == ST_REFILL) && !flush_i;
    end

    // Hit way or freshly written way becomes most recent
    always_comb begin
        plru_upd_en_c  = hit_c || wr_en_c;
        plru_upd_set_c = (state_q == ST_REFILL) ? rf_idx_c : lk_idx_c;
        plru_upd_way_c = (state_q == ST_REFILL) ? rf_way_c : hit_way_c;
    end

    cva6_l2_tlb_plru #(
        .Sets  (Sets),
        .Assoc (Assoc)
    ) u_plru (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .upd_en_i       (plru_upd_en_c),
        .upd_set_i      (plru_upd_set_c),
        .upd_way_i      (plru_upd_way_c),
        .victim_set_i   (rf_idx_c),
        .victim_way_c_o (victim_way_c)
    );

    // Next state and captured request/refill/set data
    always_comb begin
        state_d    = state_q;
        vpn_d      = vpn_q;
        asid_d     = asid_q;
        ref_vpn_d  = ref_vpn_q;
        ref_asid_d = ref_asid_q;
        ref_ppn_d  = ref_ppn_q;
        ref_perm_d = ref_perm_q;
        rd_d       = rd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!flush_i) begin
                    if (refill_valid_i) begin
                        ref_vpn_d  = refill_vpn_i;
                        ref_asid_d = refill_asid_i;
                        ref_ppn_d  = refill_ppn_i;
                        ref_perm_d = refill_perm_i;
                        state_d    = ST_REFILL;
                    end else if (req_valid_i) begin
                        vpn_d   = req_vpn_i;
                        asid_d  = req_asid_i;
                        state_d = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                // A flush in this cycle must not let the captured ways hit
                for (int unsigned w = 0; w < Assoc; w++) begin
                    rd_d[w]       = tlb_q[lk_idx_c][w];
                    rd_d[w].valid = tlb_q[lk_idx_c][w].valid && !flush_i;
                end
                state_d = ST_RESP;
            end
            ST_RESP:   state_d = ST_IDLE;
            ST_REFILL: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Control and captured-data registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            vpn_q      <= '0;
            asid_q     <= '0;
            ref_vpn_q  <= '0;
            ref_asid_q <= '0;
            ref_ppn_q  <= '0;
            ref_perm_q <= '0;
            for (int unsigned w = 0; w < Assoc; w++) begin
                rd_q[w] <= '0;
            end
        end else begin
            state_q    <= state_d;
            vpn_q      <= vpn_d;
            asid_q     <= asid_d;
            ref_vpn_q  <= ref_vpn_d;
            ref_asid_q <= ref_asid_d;
            ref_ppn_q  <= ref_ppn_d;
            ref_perm_q <= ref_perm_d;
            rd_q       <= rd_d;
        end
    end

    // Entry array: flush clears every valid bit and overrides a refill write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < Sets; s++) begin
                for (int unsigned w = 0; w < Assoc; w++) begin
                    tlb_q[s][w] <= '0;
                end
            end
        end else if (flush_i) begin
            for (int unsigned s = 0; s < Sets; s++) begin
                for (int unsigned w = 0; w < Assoc; w++) begin
                    tlb_q[s][w].valid <= 1'b0;
                end
            end
        end else if (wr_en_c) begin
            tlb_q[rf_idx_c][rf_way_c] <= rf_entry_c;
        end
    end

`ifdef CVA6_L2TLB_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating response counters, untouched by flush
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == ST_RESP) begin
            if (hit_c) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) begin
                    hit_cnt_q <= hit_cnt_q + 32'd1;
                end
            end else if (miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cva6_l2_tlb_4k.sv
// Directed bench for cva6_l2_tlb_4k: inputs driven 1 ns after the rising edge,
// outputs sampled on the falling edge.
module tb_cva6_l2_tlb_4k;

    logic         clk_i;
    logic         rst_ni;
    logic         flush_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [26:0]  req_vpn_i;
    logic [15:0]  req_asid_i;
    logic         rsp_valid_o;
    logic         rsp_hit_o;
    logic [43:0]  rsp_ppn_o;
    logic [7:0]   rsp_perm_o;
    logic         refill_valid_i;
    logic         refill_ready_o;
    logic [26:0]  refill_vpn_i;
    logic [15:0]  refill_asid_i;
    logic [43:0]  refill_ppn_i;
    logic [7:0]   refill_perm_i;
`ifdef CVA6_L2TLB_PERF_CNT_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    cva6_l2_tlb_4k dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_vpn_i      (req_vpn_i),
        .req_asid_i     (req_asid_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_hit_o      (rsp_hit_o),
        .rsp_ppn_o      (rsp_ppn_o),
        .rsp_perm_o     (rsp_perm_o),
`ifdef CVA6_L2TLB_PERF_CNT_EN
        .hit_cnt_o      (hit_cnt_o),
        .miss_cnt_o     (miss_cnt_o),
`endif
        .refill_valid_i (refill_valid_i),
        .refill_ready_o (refill_ready_o),
        .refill_vpn_i   (refill_vpn_i),
        .refill_asid_i  (refill_asid_i),
        .refill_ppn_i   (refill_ppn_i),
        .refill_perm_i  (refill_perm_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full lookup from IDLE; flush_at: 0 none, 1 during LOOKUP, 2 during RESP
    task automatic lookup(input string tag, input logic [26:0] vpn, input logic [15:0] asid,
                          input int flush_at, input logic exp_hit,
                          input logic [43:0] exp_ppn, input logic [7:0] exp_perm);
        req_valid_i = 1'b1;
        req_vpn_i   = vpn;
        req_asid_i  = asid;
        @(negedge clk_i);
        chk({tag, ".req_ready"}, 64'(req_ready_o), 64'd1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        flush_i     = (flush_at == 1);
        @(negedge clk_i);
        chk({tag, ".early_valid"}, 64'(rsp_valid_o), 64'd0);
        @(posedge clk_i); #1;
        flush_i = (flush_at == 2);
        @(negedge clk_i);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid_o), 64'd1);
        chk({tag, ".rsp_hit"},   64'(rsp_hit_o),   64'(exp_hit));
        chk({tag, ".rsp_ppn"},   64'(rsp_ppn_o),   64'(exp_ppn));
        chk({tag, ".rsp_perm"},  64'(rsp_perm_o),  64'(exp_perm));
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        chk({tag, ".after_valid"}, 64'(rsp_valid_o), 64'd0);
        chk({tag, ".after_hit"},   64'(rsp_hit_o),   64'd0);
        chk({tag, ".after_ppn"},   64'(rsp_ppn_o),   64'd0);
        @(posedge clk_i); #1;
    endtask

    // PTW leaf write from IDLE; returns in IDLE with the entry written
    task automatic refill(input string tag, input logic [26:0] vpn, input logic [15:0] asid,
                          input logic [43:0] ppn, input logic [7:0] perm);
        refill_valid_i = 1'b1;
        refill_vpn_i   = vpn;
        refill_asid_i  = asid;
        refill_ppn_i   = ppn;
        refill_perm_i  = perm;
        @(negedge clk_i);
        chk({tag, ".refill_ready"}, 64'(refill_ready_o), 64'd1);
        chk({tag, ".req_blocked"},  64'(req_ready_o),    64'd0);
        @(posedge clk_i); #1;
        refill_valid_i = 1'b0;
        @(negedge clk_i);
        chk({tag, ".busy_refill_ready"}, 64'(refill_ready_o), 64'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        rst_ni         = 1'b0;
        flush_i        = 1'b0;
        req_valid_i    = 1'b0;
        req_vpn_i      = '0;
        req_asid_i     = '0;
        refill_valid_i = 1'b0;
        refill_vpn_i   = '0;
        refill_asid_i  = '0;
        refill_ppn_i   = '0;
        refill_perm_i  = '0;

        // Reset values
        @(negedge clk_i);
        chk("rst.req_ready",    64'(req_ready_o),    64'd1);
        chk("rst.refill_ready", 64'(refill_ready_o), 64'd1);
        chk("rst.rsp_valid",    64'(rsp_valid_o),    64'd0);
        chk("rst.rsp_hit",      64'(rsp_hit_o),      64'd0);
        chk("rst.rsp_ppn",      64'(rsp_ppn_o),      64'd0);
        chk("rst.rsp_perm",     64'(rsp_perm_o),     64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Cold miss, then refill and hit
        lookup("cold_miss", 27'h0000123, 16'd1, 0, 1'b0, 44'h0, 8'h00);
        refill("rf_123", 27'h0000123, 16'd1, 44'h80001, 8'hCF);
        lookup("hit_123", 27'h0000123, 16'd1, 0, 1'b1, 44'h80001, 8'hCF);
        lookup("asid_miss_123", 27'h0000123, 16'd2, 0, 1'b0, 44'h0, 8'h00);

        // Flush in IDLE beats a simultaneous refill
        flush_i        = 1'b1;
        refill_valid_i = 1'b1;
        refill_vpn_i   = 27'h0000555;
        refill_asid_i  = 16'd1;
        refill_ppn_i   = 44'h55555;
        refill_perm_i  = 8'hCF;
        @(negedge clk_i);
        chk("flush.refill_ready", 64'(refill_ready_o), 64'd0);
        chk("flush.req_ready",    64'(req_ready_o),    64'd0);
        @(posedge clk_i); #1;
        flush_i        = 1'b0;
        refill_valid_i = 1'b0;
        @(negedge clk_i);
        chk("flush.idle_refill_ready", 64'(refill_ready_o), 64'd1);
        @(posedge clk_i); #1;
        lookup("flushed_123", 27'h0000123, 16'd1, 0, 1'b0, 44'h0, 8'h00);
        lookup("dropped_555", 27'h0000555, 16'd1, 0, 1'b0, 44'h0, 8'h00);

        // Five tags into set 3: the oldest is evicted
        for (int i = 0; i < 5; i++) begin
            refill("rf_set3", 27'((i + 1) * 32 + 3), 16'd2, 44'(32'h1000 + i), 8'h0F);
        end
        lookup("set3_evicted", 27'h0000023, 16'd2, 0, 1'b0, 44'h0, 8'h00);
        for (int i = 1; i < 5; i++) begin
            lookup("set3_kept", 27'((i + 1) * 32 + 3), 16'd2, 0, 1'b1, 44'(32'h1000 + i), 8'h0F);
        end

        // Global mapping matches any ASID; non-global does not
        refill("rf_global", 27'h0000456, 16'd1, 44'h00ABC, 8'hEF);
        lookup("global_hit", 27'h0000456, 16'd7, 0, 1'b1, 44'h00ABC, 8'hEF);
        refill("rf_nonglobal", 27'h0000789, 16'd1, 44'h00DEF, 8'hCF);
        lookup("nonglobal_miss", 27'h0000789, 16'd7, 0, 1'b0, 44'h0, 8'h00);
        lookup("nonglobal_hit", 27'h0000789, 16'd1, 0, 1'b1, 44'h00DEF, 8'hCF);

        // Same tag+ASID refill replaces the existing entry
        refill("rf_overwrite", 27'h0000789, 16'd1, 44'h0F00D, 8'hC7);
        lookup("overwrite_hit", 27'h0000789, 16'd1, 0, 1'b1, 44'h0F00D, 8'hC7);

        // Flush during LOOKUP and during RESP
        lookup("flush_in_lookup", 27'h0000456, 16'd7, 1, 1'b0, 44'h0, 8'h00);
        lookup("after_flush_lookup", 27'h0000456, 16'd1, 0, 1'b0, 44'h0, 8'h00);
        refill("rf_321", 27'h0000321, 16'd3, 44'h00777, 8'h0F);
        lookup("flush_in_resp", 27'h0000321, 16'd3, 2, 1'b0, 44'h0, 8'h00);
        lookup("after_flush_resp", 27'h0000321, 16'd3, 0, 1'b0, 44'h0, 8'h00);

        // Refill and request together: refill first, request two cycles later
        refill_valid_i = 1'b1;
        refill_vpn_i   = 27'h00002AB;
        refill_asid_i  = 16'd5;
        refill_ppn_i   = 44'hABCDE;
        refill_perm_i  = 8'hC7;
        req_valid_i    = 1'b1;
        req_vpn_i      = 27'h00002AB;
        req_asid_i     = 16'd5;
        @(negedge clk_i);
        chk("prio.refill_ready", 64'(refill_ready_o), 64'd1);
        chk("prio.req_ready",    64'(req_ready_o),    64'd0);
        @(posedge clk_i); #1;
        refill_valid_i = 1'b0;
        @(negedge clk_i);
        chk("prio.refill_busy_req_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("prio.req_accept", 64'(req_ready_o), 64'd1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("prio.early_valid", 64'(rsp_valid_o), 64'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("prio.rsp_valid", 64'(rsp_valid_o), 64'd1);
        chk("prio.rsp_hit",   64'(rsp_hit_o),   64'd1);
        chk("prio.rsp_ppn",   64'(rsp_ppn_o),   64'hABCDE);
        chk("prio.rsp_perm",  64'(rsp_perm_o),  64'hC7);
        @(posedge clk_i); #1;

        // Reset while a lookup is in flight drops it and clears entries
        req_valid_i = 1'b1;
        req_vpn_i   = 27'h00002AB;
        req_asid_i  = 16'd5;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        rst_ni      = 1'b0;
        @(negedge clk_i);
        chk("midrst.rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("midrst.req_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("midrst.no_rsp", 64'(rsp_valid_o), 64'd0);
        @(posedge clk_i); #1;
        lookup("after_reset_miss", 27'h00002AB, 16'd5, 0, 1'b0, 44'h0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
